// File: rtl/stall_pipe.sv
// DEPTH-stage valid/ready pipeline with global stall, synchronous flush and
// bubble collapsing; also reports occupancy and a saturating stall counter.
module stall_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             run_q;
  logic             blocked;
  logic             cnt_inc;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [OCC_W-1:0] occ;

  // run_q keeps the pipe closed until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign blocked = stall_i | flush_i | !run_q;

  // A stage may load if any stage at or below it (or the consumer) has room.
  always_comb begin : ready_chain
    logic room;
    room = out_ready;
    rdy  = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      room   = room | !vld_q[k];
      rdy[k] = room & !blocked;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      if (rdy[0]) begin
        vld_q[0]  <= in_valid;
        data_q[0] <= in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          vld_q[k]  <= vld_q[k-1];
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[DEPTH-1] & !stall_i & !flush_i;
  assign out_data  = data_q[DEPTH-1];

  assign cnt_inc = (stall_i & !flush_i) |
                   (vld_q[DEPTH-1] & !out_ready & !stall_i & !flush_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_cnt_q <= '0;
    else if (cnt_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(vld_q[k]);
  end

  assign occupancy = occ;

endmodule
